memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the dual-bank (even/odd byte bank, 15-bit bank address each) memory subsystem between two requesters: port 0 (instruction fetch) and port 1 (data access).
- Each granted request is a byte or 16-bit little-endian access at a 16-bit byte address. The arbiter splits it into even/odd bank addresses, drives bank write enables, and realigns returned read data.
- Sits between the CPU core's fetch/data units and the memory subsystem. Memory read data returns one clock after the address.

Parameters:
- FIXED_PRIO, 0, 1 = port 0 always wins contention; 0 = round-robin between ports.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req, p1_req  in  1  access request; held until granted
- p0_addr, p1_addr  in  16  byte address
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_wide, p1_wide  in  1  1 = 16-bit access, 0 = byte access
- p0_wdata, p1_wdata  in  16  write data; bits [7:0] to addr, [15:8] to addr+1
- p0_gnt, p1_gnt  out  1  request accepted this cycle
- p0_rvalid, p1_rvalid  out  1  read data valid; cycle after read grant
- p0_rdata, p1_rdata  out  16  read data; [15:8] = 0 for byte reads
- read_addr_even, read_addr_odd  out  15  bank read addresses
- read_data_even, read_data_odd  in  8  bank read data, 1-cycle latency
- write_addr_even, write_addr_odd  out  15  bank write addresses
- write_data_even, write_data_odd  out  8  bank write data
- write_en_even, write_en_odd  out  1  bank write enables

Behaviour:
- Reset (async): all gnt, rvalid and write_en = 0; rdata = 0; round-robin pointer favours port 0; pending-read register cleared.
- Arbitration is combinational within the cycle; at most one gnt per cycle.
  - Single requester is granted immediately.
  - On contention, FIXED_PRIO=1 grants port 0.
  - Otherwise round-robin: the port not granted last wins; the pointer updates only on a grant.
- Address split for granted access A:
  - lo = A, hi = A+1 (mod 2^16; 0xFFFF wraps hi to 0x0000).
  - A even: even bank addr = A[15:1]; odd bank addr = A[15:1].
  - A odd: odd bank addr = A[15:1]; even bank addr = (A+1)[15:1].
  - Both read and write addresses driven identically from the granted request.
  - With no grant, addresses hold their previous value; write_en = 0.
- Write:
  - Byte write asserts only the bank holding lo, with wdata[7:0].
  - Wide write asserts both banks: lo byte = wdata[7:0], hi byte = wdata[15:8].
  - Write completes in the grant cycle; no rvalid.
- Read:
  - Register {owner, A[0], wide} at grant.
  - Next cycle pulse owner's rvalid for 1 cycle with rdata assembled from read_data_even/odd per registered A[0]: even → {odd, even}; odd → {even, odd}.
  - For byte reads, mask [15:8] to 0.
  - rdata registered-free (combinational from bank data); undefined when rvalid=0 but is 0 after reset until first read.
- Back-to-back grants every cycle are allowed; throughput is 1 access/cycle. A read grant and a subsequent write grant in consecutive cycles do not interfere.
- Reset mid-read: the pending rvalid is dropped and never issued.
- A requester dropping req before gnt is legal; no state is kept.

Optional Feature:
- Macro MEMARB_LOCK_EN.
- Defined: adds inputs p0_lock, p1_lock (1 bit).
  - A port granted with lock=1 owns the arbiter: the other port receives no gnt until the owner's lock is sampled 0 on a granted or idle cycle.
  - Intended for read-modify-write.
  - Lock ownership cleared by reset.
- Not defined: no lock ports; pure arbitration as above.

Test Plan:
- Reset, then p0 byte write A=0x0004 data 0x00AB, then wide read A=0x0004 → write_en_even only, write_addr_even=0x0002; next read p0_rvalid=1 cycle after gnt, p0_rdata=0x00AB.
- p1 wide write A=0x0007 data 0x1234 → write_en_odd (addr 0x0003, data 0x34) and write_en_even (addr 0x0004, data 0x12) same cycle; wide read 0x0007 → p1_rdata=0x1234.
- Wide write 0xFFFF data 0xBEEF → odd addr 0x7FFF=0xEF, even addr 0x0000=0xBE; wide read 0xFFFF returns 0xBEEF.
- Both req every cycle for 6 cycles, FIXED_PRIO=0 → grants alternate p0,p1,p0,p1,p0,p1; FIXED_PRIO=1 → p0 six times, p1 none.
- p0 read granted, reset asserted next cycle → p0_rvalid stays 0; all gnt and write_en 0 while reset high.
- MEMARB_LOCK_EN: p1 granted with p1_lock=1, p0_req held 4 cycles → p0_gnt=0 until p1_lock=0, then p0 granted next cycle.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port arbiter onto the even/odd byte-banked memory: address split, bank write enables, read realignment.
// Optional MEMARB_LOCK_EN adds p0_lock/p1_lock so a port can hold the arbiter for read-modify-write.
module memory_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p1_addr,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic        p0_wide,
    input  logic        p1_wide,
    input  logic [15:0] p0_wdata,
    input  logic [15:0] p1_wdata,
`ifdef MEMARB_LOCK_EN
    input  logic        p0_lock,
    input  logic        p1_lock,
`endif
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [15:0] p0_rdata,
    output logic [15:0] p1_rdata,
    output logic [14:0] read_addr_even,
    output logic [14:0] read_addr_odd,
    input  logic [7:0]  read_data_even,
    input  logic [7:0]  read_data_odd,
    output logic [14:0] write_addr_even,
    output logic [14:0] write_addr_odd,
    output logic [7:0]  write_data_even,
    output logic [7:0]  write_data_odd,
    output logic        write_en_even,
    output logic        write_en_odd
);

    logic        rr_q, rr_d;          // 1: port 1 wins the next contention
    logic        req0_eff, req1_eff;
    logic        any_gnt, sel;
    logic [15:0] a, a_inc, wd;
    logic        s_we, s_wide;
    logic [14:0] ev_addr, od_addr;
    logic [14:0] addr_e_q, addr_o_q;
    logic        pend_vld_q, pend_own_q, pend_odd_q, pend_wide_q;
    logic [15:0] asm_data;

`ifdef MEMARB_LOCK_EN
    logic lock_vld_q, lock_own_q, own_req, own_lock, s_lock;

    assign req0_eff = p0_req && !(lock_vld_q && lock_own_q);
    assign req1_eff = p1_req && !(lock_vld_q && !lock_own_q);
    assign own_req  = lock_own_q ? p1_req  : p0_req;
    assign own_lock = lock_own_q ? p1_lock : p0_lock;
    assign s_lock   = sel ? p1_lock : p0_lock;

    // Ownership ends once the owner shows lock=0 while granted or not requesting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
        end else if (any_gnt) begin
            lock_vld_q <= s_lock;
            lock_own_q <= sel;
        end else if (lock_vld_q && !own_req && !own_lock) begin
            lock_vld_q <= 1'b0;
        end
    end
`else
    assign req0_eff = p0_req;
    assign req1_eff = p1_req;
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            if (req0_eff && req1_eff) begin
                if (FIXED_PRIO != 0 || !rr_q) p0_gnt = 1'b1;
                else                          p1_gnt = 1'b1;
            end else begin
                p0_gnt = req0_eff;
                p1_gnt = req1_eff;
            end
        end
    end

    assign any_gnt = p0_gnt || p1_gnt;
    assign sel     = p1_gnt;
    assign a       = sel ? p1_addr  : p0_addr;
    assign wd      = sel ? p1_wdata : p0_wdata;
    assign s_we    = sel ? p1_we    : p0_we;
    assign s_wide  = sel ? p1_wide  : p0_wide;
    assign a_inc   = a + 16'd1;

    // Odd bank always holds A's word; for odd A the high byte is in the next even word.
    assign od_addr = a[15:1];
    assign ev_addr = a[0] ? a_inc[15:1] : a[15:1];

    assign read_addr_even  = any_gnt ? ev_addr : addr_e_q;
    assign read_addr_odd   = any_gnt ? od_addr : addr_o_q;
    assign write_addr_even = read_addr_even;
    assign write_addr_odd  = read_addr_odd;

    assign write_en_even   = any_gnt && s_we && (s_wide || !a[0]);
    assign write_en_odd    = any_gnt && s_we && (s_wide ||  a[0]);
    assign write_data_even = a[0] ? wd[15:8] : wd[7:0];
    assign write_data_odd  = a[0] ? wd[7:0]  : wd[15:8];

    always_comb begin
        rr_d = rr_q;
        if (p0_gnt)      rr_d = 1'b1;
        else if (p1_gnt) rr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q        <= 1'b0;
            addr_e_q    <= '0;
            addr_o_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_own_q  <= 1'b0;
            pend_odd_q  <= 1'b0;
            pend_wide_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            pend_vld_q <= any_gnt && !s_we;
            if (any_gnt) begin
                addr_e_q    <= ev_addr;
                addr_o_q    <= od_addr;
                pend_own_q  <= sel;
                pend_odd_q  <= a[0];
                pend_wide_q <= s_wide;
            end
        end
    end

    always_comb begin
        asm_data = pend_odd_q ? {read_data_even, read_data_odd}
                              : {read_data_odd, read_data_even};
        if (!pend_wide_q) asm_data[15:8] = 8'h00;
    end

    assign p0_rvalid = pend_vld_q && !pend_own_q;
    assign p1_rvalid = pend_vld_q &&  pend_own_q;
    assign p0_rdata  = p0_rvalid ? asm_data : 16'h0000;
    assign p1_rdata  = p1_rvalid ? asm_data : 16'h0000;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: vector table plus reset, contention and lock sequences.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 0, p1_req = 0, p0_we = 0, p1_we = 0, p0_wide = 0, p1_wide = 0;
    logic [15:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
`ifdef MEMARB_LOCK_EN
    logic        p0_lock = 0, p1_lock = 0;
`endif
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [14:0] ra_e, ra_o, wa_e, wa_o;
    logic [7:0]  rd_e, rd_o, wd_e, wd_o;
    logic        we_e, we_o;
    logic        f_g0, f_g1, f_rv0, f_rv1, f_we_e, f_we_o;
    logic [15:0] f_rd0, f_rd1;
    logic [14:0] f_ra_e, f_ra_o, f_wa_e, f_wa_o;
    logic [7:0]  f_wd_e, f_wd_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p1_req(p1_req), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_we(p0_we), .p1_we(p1_we), .p0_wide(p0_wide), .p1_wide(p1_wide),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
`ifdef MEMARB_LOCK_EN
        .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .read_addr_even(ra_e), .read_addr_odd(ra_o),
        .read_data_even(rd_e), .read_data_odd(rd_o),
        .write_addr_even(wa_e), .write_addr_odd(wa_o),
        .write_data_even(wd_e), .write_data_odd(wd_o),
        .write_en_even(we_e), .write_en_odd(we_o)
    );

    memory_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p1_req(p1_req), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_we(p0_we), .p1_we(p1_we), .p0_wide(p0_wide), .p1_wide(p1_wide),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
`ifdef MEMARB_LOCK_EN
        .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
        .p0_gnt(f_g0), .p1_gnt(f_g1), .p0_rvalid(f_rv0), .p1_rvalid(f_rv1),
        .p0_rdata(f_rd0), .p1_rdata(f_rd1),
        .read_addr_even(f_ra_e), .read_addr_odd(f_ra_o),
        .read_data_even(rd_e), .read_data_odd(rd_o),
        .write_addr_even(f_wa_e), .write_addr_odd(f_wa_o),
        .write_data_even(f_wd_e), .write_data_odd(f_wd_o),
        .write_en_even(f_we_e), .write_en_odd(f_we_o)
    );

    // Bank model: synchronous write, registered read (1-cycle latency).
    logic [7:0] mem_e [0:32767];
    logic [7:0] mem_o [0:32767];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32768; i++) begin
                mem_e[i] <= 8'h00;
                mem_o[i] <= 8'h00;
            end
            rd_e <= 8'h00;
            rd_o <= 8'h00;
        end else begin
            if (we_e) mem_e[wa_e] <= wd_e;
            if (we_o) mem_o[wa_o] <= wd_o;
            rd_e <= mem_e[ra_e];
            rd_o <= mem_o[ra_o];
        end
    end

    typedef struct {
        logic        r0, r1, we0, we1, w0, w1;
        logic [15:0] a0, a1, d0, d1;
        logic        g0, g1, ee, eo, rv0, rv1;
        logic [14:0] wae, wao;
        logic [7:0]  wde, wdo;
        logic [15:0] rd0, rd1;
    } vec_t;

    function automatic vec_t rq(input int p, input logic we, input logic wide,
                                input logic [15:0] a, input logic [15:0] d);
        vec_t v;
        v = '{default: 0};
        if (p == 0) begin v.r0 = 1; v.we0 = we; v.w0 = wide; v.a0 = a; v.d0 = d; end
        else if (p == 1) begin v.r1 = 1; v.we1 = we; v.w1 = wide; v.a1 = a; v.d1 = d; end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        p0_req = v.r0; p0_we = v.we0; p0_wide = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_we = v.we1; p1_wide = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t v [14];

    initial begin
        vec_t idle;
        logic ok;
        idle = rq(-1, 0, 0, 16'h0, 16'h0);

        v[0] = rq(0, 1, 0, 16'h0004, 16'h00AB); v[0].g0 = 1; v[0].ee = 1; v[0].wae = 15'h0002; v[0].wde = 8'hAB;
        v[1] = rq(0, 0, 1, 16'h0004, 16'h0000); v[1].g0 = 1;
        v[2] = idle; v[2].rv0 = 1; v[2].rd0 = 16'h00AB;
        v[3] = rq(1, 1, 1, 16'h0007, 16'h1234); v[3].g1 = 1; v[3].ee = 1; v[3].eo = 1;
        v[3].wae = 15'h0004; v[3].wde = 8'h12; v[3].wao = 15'h0003; v[3].wdo = 8'h34;
        v[4] = rq(1, 0, 1, 16'h0007, 16'h0000); v[4].g1 = 1;
        v[5] = idle; v[5].rv1 = 1; v[5].rd1 = 16'h1234;
        v[6] = rq(0, 1, 1, 16'hFFFF, 16'hBEEF); v[6].g0 = 1; v[6].ee = 1; v[6].eo = 1;
        v[6].wae = 15'h0000; v[6].wde = 8'hBE; v[6].wao = 15'h7FFF; v[6].wdo = 8'hEF;
        v[7] = rq(0, 0, 1, 16'hFFFF, 16'h0000); v[7].g0 = 1;
        v[8] = idle; v[8].rv0 = 1; v[8].rd0 = 16'hBEEF;
        v[9] = rq(1, 0, 0, 16'h0007, 16'h0000); v[9].g1 = 1;
        v[10] = rq(0, 0, 0, 16'h0004, 16'h0000); v[10].g0 = 1; v[10].rv1 = 1; v[10].rd1 = 16'h0034;
        v[11] = rq(0, 1, 0, 16'h0009, 16'h0077); v[11].g0 = 1; v[11].eo = 1;
        v[11].wao = 15'h0004; v[11].wdo = 8'h77; v[11].rv0 = 1; v[11].rd0 = 16'h00AB;
        v[12] = rq(0, 0, 0, 16'h0004, 16'h0000); v[12].r1 = 1; v[12].a1 = 16'h0009; v[12].g1 = 1;
        v[13] = idle; v[13].rv1 = 1; v[13].rd1 = 16'h0077;

        // Reset state, with requests asserted to show the grant gating.
        @(negedge clk);
        p0_req = 1; p0_we = 1; p1_req = 1;
        #1;
        chk("reset_gnt", {p0_gnt, p1_gnt, f_g0, f_g1}, 0);
        chk("reset_we", {we_e, we_o}, 0);
        chk("reset_rv", {p0_rvalid, p1_rvalid, p0_rdata, p1_rdata}, 0);
        @(negedge clk);
        drive(idle);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            ok = (p0_gnt === v[i].g0) && (p1_gnt === v[i].g1) && (we_e === v[i].ee) &&
                 (we_o === v[i].eo) && (p0_rvalid === v[i].rv0) && (p1_rvalid === v[i].rv1);
            if (v[i].ee) ok = ok && (wa_e === v[i].wae) && (wd_e === v[i].wde);
            if (v[i].eo) ok = ok && (wa_o === v[i].wao) && (wd_o === v[i].wdo);
            if (v[i].rv0) ok = ok && (p0_rdata === v[i].rd0);
            if (v[i].rv1) ok = ok && (p1_rdata === v[i].rd1);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got gnt=%b%b we=%b%b wa_e=%h wd_e=%h wa_o=%h wd_o=%h rv=%b%b rd0=%h rd1=%h; expected gnt=%b%b we=%b%b wa_e=%h wd_e=%h wa_o=%h wd_o=%h rv=%b%b rd0=%h rd1=%h",
                         i, p0_gnt, p1_gnt, we_e, we_o, wa_e, wd_e, wa_o, wd_o, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
                         v[i].g0, v[i].g1, v[i].ee, v[i].eo, v[i].wae, v[i].wde, v[i].wao, v[i].wdo,
                         v[i].rv0, v[i].rv1, v[i].rd0, v[i].rd1);
            end
        end

        // Address hold with no grant: last granted was p1 at 0x0009 (even word 5, odd word 4).
        @(negedge clk);
        drive(idle);
        #1;
        chk("addr_hold", {2'b00, ra_e, ra_o}, {2'b00, 15'h0005, 15'h0004});

        // Continuous contention; round-robin last granted p1 so p0 leads.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            p0_req = 1; p0_we = 0; p0_addr = 16'h0000;
            p1_req = 1; p1_we = 0; p1_addr = 16'h0000;
            #1;
            chk($sformatf("rr_cyc%0d", c), {p0_gnt, p1_gnt}, (c % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("fp_cyc%0d", c), {f_g0, f_g1}, 2'b10);
        end

        // Reset right after a read grant drops the pending rvalid.
        @(negedge clk);
        drive(rq(0, 0, 0, 16'h0004, 16'h0000));
        #1;
        chk("rst_rd_gnt", p0_gnt, 1);
        @(posedge clk);
        reset = 1'b1;
        p0_we = 1; p1_req = 1;
        @(negedge clk);
        #1;
        chk("rst_mid_rv", {p0_rvalid, p1_rvalid}, 0);
        chk("rst_mid_gnt", {p0_gnt, p1_gnt, we_e, we_o}, 0);
        @(negedge clk);
        drive(idle);
        reset = 1'b0;
        #1;
        chk("rst_after_rv", {p0_rvalid, p1_rvalid}, 0);

`ifdef MEMARB_LOCK_EN
        // p1 locks, then idles; p0 waits until p1 shows lock=0.
        @(negedge clk);
        drive(rq(1, 0, 0, 16'h0002, 16'h0000));
        p1_lock = 1;
        #1;
        chk("lock_p1_gnt", p1_gnt, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(rq(0, 0, 0, 16'h0004, 16'h0000));
            if (c == 3) p1_lock = 0;
            #1;
            chk($sformatf("lock_wait%0d", c), p0_gnt, 0);
        end
        @(negedge clk);
        #1;
        chk("lock_release", p0_gnt, 1);
        drive(idle);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
